// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants and state type for the systolic operand feeder
package systolic_pkg;
    localparam int N          = 4;
    localparam int DW         = 32;
    localparam int STREAM_LEN = 3 * N - 2;
    localparam int IDX_W      = $clog2(N);
    localparam int T_W        = $clog2(STREAM_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        STREAM,
        DONE
    } state_t;
endpackage

// File: rtl/systolic_feeder_4x4_feed_lane_sel.sv
// rtl/systolic_feeder_4x4_feed_lane_sel.sv - picks the skewed element for one lane at stream step t
module feed_lane_sel #(
    parameter int N  = systolic_pkg::N,
    parameter int DW = systolic_pkg::DW,
    parameter int TW = systolic_pkg::T_W
) (
    input  logic [$clog2(N)-1:0] lane,
    input  logic [TW-1:0]        t,
    input  logic [N*DW-1:0]      elems,
    output logic [DW-1:0]        data
);
    // t == lane + m is the in-range test for index t-lane without any unsigned underflow
    always_comb begin
        data = '0;
        for (int m = 0; m < N; m++) begin
            if (t == TW'(lane) + TW'(m)) begin
                data = elems[m*DW +: DW];
            end
        end
    end
endmodule

// File: rtl/systolic_feeder_4x4.sv
// rtl/systolic_feeder_4x4.sv - operand store and skewed west/north stream generator for a 4x4 array
module systolic_feeder_4x4 #(
    parameter int DW = systolic_pkg::DW,
    parameter int N  = systolic_pkg::N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [$clog2(N)-1:0] wr_row,
    input  logic [$clog2(N)-1:0] wr_col,
    input  logic [DW-1:0]        wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 arr_clr,
    output logic [N*DW-1:0]      west_out,
    output logic [N*DW-1:0]      north_out,
    output logic                 done
);
    import systolic_pkg::state_t;
    import systolic_pkg::IDLE;
    import systolic_pkg::CLR;
    import systolic_pkg::STREAM;
    import systolic_pkg::DONE;

    localparam int LEN = 3 * N - 2;
    localparam int TW  = $clog2(LEN) + 1;
    localparam int IW  = $clog2(N);

    state_t        state, state_nx;
    logic [TW-1:0] t, t_nx;

    logic [DW-1:0]   a_mem [N][N];
    logic [DW-1:0]   b_mem [N][N];
    logic [N*DW-1:0] a_row [N];
    logic [N*DW-1:0] b_col [N];
    logic [DW-1:0]   west_sel  [N];
    logic [DW-1:0]   north_sel [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            t     <= '0;
        end else begin
            state <= state_nx;
            t     <= t_nx;
        end
    end

    // start coinciding with a write loses to the write
    always_comb begin
        state_nx = state;
        t_nx     = t;
        case (state)
            IDLE: begin
                if (start && !wr_en) state_nx = CLR;
            end
            CLR: begin
                state_nx = STREAM;
                t_nx     = '0;
            end
            STREAM: begin
                if (t == TW'(LEN - 1)) state_nx = DONE;
                else                   t_nx     = t + 1'b1;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else if (wr_en && state == IDLE) begin
            if (wr_sel) b_mem[wr_row][wr_col] <= wr_data;
            else        a_mem[wr_row][wr_col] <= wr_data;
        end
    end

    // west lane i walks row i of A; north lane j walks column j of B
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_row[i] = '0;
            b_col[i] = '0;
            for (int k = 0; k < N; k++) begin
                a_row[i][k*DW +: DW] = a_mem[i][k];
                b_col[i][k*DW +: DW] = b_mem[k][i];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        feed_lane_sel #(.N(N), .DW(DW), .TW(TW)) u_west (
            .lane  (IW'(g)),
            .t     (t_nx),
            .elems (a_row[g]),
            .data  (west_sel[g])
        );
        feed_lane_sel #(.N(N), .DW(DW), .TW(TW)) u_north (
            .lane  (IW'(g)),
            .t     (t_nx),
            .elems (b_col[g]),
            .data  (north_sel[g])
        );
    end

    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            arr_clr   <= 1'b0;
            done      <= 1'b0;
            west_out  <= '0;
            north_out <= '0;
        end else begin
            busy    <= (state_nx == CLR) || (state_nx == STREAM);
            arr_clr <= (state_nx == CLR);
            done    <= (state_nx == DONE);
            for (int l = 0; l < N; l++) begin
                west_out[l*DW +: DW]  <= (state_nx == STREAM) ? west_sel[l]  : '0;
                north_out[l*DW +: DW] <= (state_nx == STREAM) ? north_sel[l] : '0;
            end
        end
    end
endmodule

// File: doc/systolic_feeder_4x4.md
Name: systolic_feeder_4x4

Overview:
- Operand feeder that sits in front of the 4x4 output-stationary systolic array.
- Holds two NxN operand matrices, A (row operands) and B (column operands), loaded through a simple write port.
- On start, emits the diagonally skewed west and north streams the array consumes, then zero-flushes until the last PE has accumulated.
- Drives a one-cycle array clear before streaming and reports done and busy.

Parameters:
- DW, 32, operand width in bits.
- N, 4, array dimension. All counts and timings below scale with N; the values quoted are for N=4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  operand write strobe.
- wr_sel  in  1  write target: 0 = A, 1 = B.
- wr_row  in  $clog2(N)  element row index.
- wr_col  in  $clog2(N)  element column index.
- wr_data  in  DW  element value.
- start  in  1  single-cycle request to run one matrix product.
- busy  out  1  high from the cycle after start is accepted through the last flush cycle.
- arr_clr  out  1  one-cycle pulse; ORed with system reset into the array's rst.
- west_out  out  N*DW  lane i occupies bits [i*DW +: DW] and drives array row i's west input.
- north_out  out  N*DW  lane j occupies bits [j*DW +: DW] and drives array column j's north input.
- done  out  1  one-cycle pulse after the final accumulate cycle.

Behaviour:
- Reset: state IDLE; busy, arr_clr and done at 0; west_out and north_out at 0; all A and B storage cleared to 0.
- All outputs are registered. No combinational path from inputs to outputs.
- States:
  - IDLE: outputs zero.
  - CLR: exactly 1 cycle, arr_clr=1, data outputs zero.
  - STREAM: 3N-2 = 10 cycles, local counter t = 0..3N-3.
  - DONE: 1 cycle, done=1, busy=0, then return to IDLE.
- Start acceptance: start is accepted only in IDLE with wr_en=0. start during CLR, STREAM or DONE is ignored. start in the same cycle as wr_en is ignored; the write still commits.
- Writes: accepted only in IDLE. Writes in any other state are dropped silently. A write commits at the sampling edge and is visible to any later stream.
- Stream content in STREAM cycle t:
  - West lane i carries A[i][t-i] when 0 <= t-i < N, else 0.
  - North lane j carries B[t-j][j] when 0 <= t-j < N, else 0.
  - Data appears in cycles t = 0..2N-2 (7). Cycles 2N-1..3N-3 (3) are zero flush, giving PE(N-1,N-1) its last operands at t=3N-3.
- Timing from the start edge E0: CLR occupies cycle E0+1, t=0 is cycle E0+2, done is high in cycle E0+3N.
- Busy: high in CLR and STREAM (11 cycles); low in IDLE and DONE.
- Back-to-back runs: a start in the DONE cycle is ignored. A new start is accepted at the earliest in the cycle after done.
- Reset mid-operation: asynchronous return to IDLE; outputs zero immediately; storage cleared; no done pulse is produced.
- Width rules: data passes through unmodified, with no arithmetic on operands. t is $clog2(3N-2)+1 bits wide and does not wrap within a run.

Decomposition:
- Shared package systolic_pkg:
  - constants: N, DW, STREAM_LEN = 3*N-2, IDX_W = $clog2(N);
  - state enum {IDLE, CLR, STREAM, DONE}.
- One sub-module, feed_lane_sel: combinational per-lane selector.
  - Inputs: lane index, t, and the lane's N stored elements.
  - Output: the element at index t-lane when in range, else 0.
  - Instantiated 2N times (N west lanes, N north lanes). Output registers stay in the top.

Test Plan:
- Reset: assert rst mid-cycle -> busy, done, arr_clr, west_out and north_out read 0 asynchronously; read-back run streams all zeros.
- Stream shape: load A[i][k] = 4i+k+1 and B[k][j] = 16+4k+j+1, then start.
  - arr_clr is high only in cycle E0+1.
  - West lane0 over t=0..9: 1,2,3,4,0,0,0,0,0,0.
  - West lane3: zero until t=3, then 13,14,15,16, then zeros.
  - North lane2: 0,0,19,23,27,31,0,0,0,0.
- Timing: done is high only in cycle E0+12; busy is high for exactly cycles E0+1..E0+11.
- Ignored requests:
  - start pulses at t=2 and in the DONE cycle -> no extra run.
  - wr_en A[0][0]=99 at t=5 -> the next run still emits 1 on west lane0 at t=0.
- Same-cycle write and start in IDLE: write A[1][1]=7 with start high -> no run starts, busy stays 0; the next start emits 7 on west lane1 at t=2.
- Reset mid-stream at t=4 -> outputs 0 immediately, no done pulse; a new start streams zeros on all lanes.
- End to end with the 4x4 array, A = B = identity: after done, PE(i,i) results are 1 and all others 0. With the stream-shape matrices, each PE result equals the software A*B product.
